bidir_bus_port: RTL and testbench
=================================

// Module: bidir_bus_port
//
// PURPOSE
// - Registered port onto a shared tri-state data bus: drives the bus only while
//   granted, and receives words driven by other agents into a small RX FIFO.
// - Sits between a local producer/consumer and the bus. Provides the request/grant,
//   drive/turnaround sequencing and receive buffering around the bus.
//
// PARAMETERS
// - N        4   bus and data width, in bits.
// - DEPTH    4   RX FIFO depth in words. Must be a power of 2 and at least 2.
// - TIMEOUT  16  cycles REQ waits for a grant. Used only when BUS_TIMEOUT_EN is defined.
//
// PORTS
// - clk          in     1  single clock; all sequential logic updates on the rising edge.
// - rst_n        in     1  reset, asynchronous, active-low.
// - bus          inout  N  shared bus. Equals drv_q when oe=1, else {N{1'bz}}.
// - bus_req      out    1  request for bus ownership.
// - bus_gnt      in     1  grant from the external arbiter.
// - bus_stb_o    out    1  strobe: this port is driving valid data this cycle.
// - bus_stb_i    in     1  strobe: another agent is driving valid data this cycle.
// - tx_valid     in     1  local word offered for transmit.
// - tx_data      in     N  local transmit word.
// - tx_ready     out    1  port accepts tx_data. High only in IDLE.
// - rx_valid     out    1  RX FIFO is not empty.
// - rx_data      out    N  RX FIFO head (first-word fall-through).
// - rx_ready     in     1  consumer pops the head when rx_valid=1.
// - rx_overflow  out    1  one-cycle pulse: a received word was dropped because the FIFO was full.
// - timeout_err  out    1  one-cycle pulse: the pending tx word was dropped (timeout). Tied to 0 without the macro.
//
// BEHAVIOUR
// - Reset (rst_n=0, takes effect immediately, asynchronously):
//   - state=IDLE, oe=0 (bus released at once), drv_q=0, bus_req=0, bus_stb_o=0.
//   - FIFO pointers and count = 0, so rx_valid=0; rx_data=0.
//   - rx_overflow=0, timeout_err=0. tx_ready=1 from the first cycle after release.
// - TX state machine:
//   - IDLE -> REQ: on tx_valid & tx_ready, capture tx_data into drv_q; bus_req=1 from the next cycle.
//   - REQ: hold bus_req=1. At a rising edge with bus_gnt=1 -> DRIVE.
//   - DRIVE (exactly 1 cycle): oe=1, bus_stb_o=1, bus_req=1; then -> TURN.
//   - TURN (exactly 1 cycle): oe=0, bus_req=0, bus_stb_o=0; then -> IDLE.
//     This guarantees one bus-free turnaround cycle.
//   - oe is a registered decode of state: no combinational path to the bus.
//   - Latency: tx accepted at edge k; if bus_gnt=1 at edge k+1, the bus is driven
//     during cycle k+1..k+2. tx_ready returns at edge k+3.
//   - bus_gnt dropping while in DRIVE does not shorten the drive cycle.
// - RX path:
//   - At each edge with bus_stb_i=1 and state != DRIVE, sample bus and push it into the FIFO.
//   - bus_stb_i during DRIVE is ignored (own cycle).
//   - Pop occurs when rx_valid & rx_ready. rx_data updates to the next entry on the same edge.
//   - Full, push only: word dropped; rx_overflow=1 for the following cycle; FIFO unchanged.
//   - Full, push and pop together: both accepted, count unchanged, no overflow.
//   - Empty, push and pop together: pop is ignored (rx_valid=0); push accepted.
//   - Read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
//
// CONFIGURATION
// - BUS_TIMEOUT_EN defined:
//   - A counter clears on entry to REQ and increments each REQ cycle without grant.
//   - When it reaches TIMEOUT, the next state is IDLE and the word is dropped;
//     timeout_err pulses for 1 cycle; bus never driven.
//   - A grant in the same cycle as the timeout wins: the word is driven and no error pulse occurs.
// - BUS_TIMEOUT_EN undefined:
//   - REQ waits indefinitely; timeout_err is constant 0; no counter is instantiated.
//
// TESTING
// - T1: N=4. Reset; tx_valid=1, tx_data=12, bus_gnt=1 ->
//   - bus=4'hC with bus_stb_o=1 for exactly 1 cycle, preceded by bus_req=1.
//   - Then bus=4'bzzzz for the TURN cycle; tx_ready=1 one cycle later.
// - T2: remote drives bus=10 with bus_stb_i=1 for 1 cycle, rx_ready=0 ->
//   - rx_valid=1 and rx_data=10 after that edge; stays until popped.
// - T3: DEPTH=4, rx_ready=0. Push 1,2,3,4,5 on consecutive cycles ->
//   - rx_overflow pulses once after word 5 only; pops return 1,2,3,4, then rx_valid=0.
// - T4: FIFO full; push 7 while rx_ready=1 ->
//   - no overflow; count stays 4; 7 is read last.
// - T5: BUS_TIMEOUT_EN on, TIMEOUT=16, bus_gnt=0 for 20 cycles after tx 9 ->
//   - timeout_err pulses once; bus never leaves Z; tx_ready=1 afterwards.
//   - Macro off: still in REQ with bus_req=1 after 20 cycles.
// - T6: rst_n=0 asserted mid-DRIVE (no clock edge) with FIFO holding 2 words ->
//   - bus goes Z and bus_req=0 immediately; rx_valid=0.
//   - After release, a new tx completes normally.

Source files
------------

// File: rtl/bidir_bus_port.sv
// bidir_bus_port: registered tri-state bus port with request/grant TX sequencing and an RX FIFO
// Ports: clk, rst_n (async active-low); bus (inout N); bus_req/bus_gnt arbitration;
// bus_stb_o/bus_stb_i data strobes; tx_valid/tx_data/tx_ready local transmit;
// rx_valid/rx_data/rx_ready first-word fall-through receive; rx_overflow, timeout_err pulses.
// Optional: define BUS_TIMEOUT_EN to drop a pending tx word after TIMEOUT ungranted REQ cycles.
module bidir_bus_port #(
  parameter int N       = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  inout  wire  [N-1:0] bus,
  output logic         bus_req,
  input  logic         bus_gnt,
  output logic         bus_stb_o,
  input  logic         bus_stb_i,
  input  logic         tx_valid,
  input  logic [N-1:0] tx_data,
  output logic         tx_ready,
  output logic         rx_valid,
  output logic [N-1:0] rx_data,
  input  logic         rx_ready,
  output logic         rx_overflow,
  output logic         timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DRIVE = 2'd2, TURN = 2'd3;
  localparam int AW = $clog2(DEPTH);
  logic [1:0] state, nxt;
  logic oe, tmo, push_req, push, pop, full;
  logic [N-1:0] drv_q;
  logic [N-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign bus = oe ? drv_q : {N{1'bz}};
  assign bus_stb_o = oe;
  assign tx_ready = state == IDLE;
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  // a grant on the last waiting cycle takes precedence over the timeout
  assign tmo = state == REQ && !bus_gnt && tcnt == TLAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= state == REQ ? tcnt + 1'b1 : '0;
      timeout_err <= tmo;
    end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb
    nxt = state == IDLE  ? (tx_valid ? REQ : IDLE) :
          state == REQ   ? (bus_gnt ? DRIVE : tmo ? IDLE : REQ) :
          state == DRIVE ? TURN : IDLE;
  // oe and bus_req are registered decodes of the next state so the bus enable is glitch-free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      oe <= 1'b0;
      bus_req <= 1'b0;
      drv_q <= '0;
    end else begin
      state <= nxt;
      oe <= nxt == DRIVE;
      bus_req <= nxt == REQ || nxt == DRIVE;
      if (state == IDLE && tx_valid) drv_q <= tx_data;
    end
  assign push_req = bus_stb_i && state != DRIVE;
  assign full = cnt[AW];
  assign rx_valid = cnt != '0;
  assign pop = rx_valid && rx_ready;
  assign push = push_req && (!full || pop);
  assign rx_data = rx_valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= bus;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rx_overflow <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      rx_overflow <= push_req && full && !pop;
    end
endmodule

// File: tb/tb_bidir_bus_port.sv
// tb_bidir_bus_port: directed table-driven bench for bidir_bus_port
module tb_bidir_bus_port;
  logic clk = 1'b0, rst_n = 1'b0;
  logic bus_gnt = 1'b0, bus_stb_i = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0;
  logic [3:0] tx_data = '0, rdat = '0;
  logic rdrv = 1'b0;
  logic bus_req, bus_stb_o, tx_ready, rx_valid, rx_overflow, timeout_err;
  logic [3:0] rx_data;
  tri1 [3:0] bus;
  int errors = 0, checks = 0;

  assign bus = rdrv ? rdat : 4'bzzzz;
  always #5 clk = ~clk;

  bidir_bus_port #(.N(4), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_stb_o(bus_stb_o), .bus_stb_i(bus_stb_i), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .timeout_err(timeout_err));

  typedef struct {
    logic stb;
    logic [3:0] d;
    logic rdy;
    logic v;
    logic [3:0] q;
    logic o;
  } rx_vec_t;
  rx_vec_t vec [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_drive(input logic stb, input logic [3:0] d, input logic rdy);
    bus_stb_i = stb;
    rdrv = stb;
    rdat = d;
    rx_ready = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses, driven;
    vec = '{
      '{1, 4'd10, 0, 1, 4'd10, 0},
      '{0, 4'd0,  0, 1, 4'd10, 0},
      '{0, 4'd0,  1, 0, 4'd0,  0},
      '{1, 4'd1,  0, 1, 4'd1,  0},
      '{1, 4'd2,  0, 1, 4'd1,  0},
      '{1, 4'd3,  0, 1, 4'd1,  0},
      '{1, 4'd4,  0, 1, 4'd1,  0},
      '{1, 4'd5,  0, 1, 4'd1,  1},
      '{0, 4'd0,  0, 1, 4'd1,  0},
      '{1, 4'd7,  1, 1, 4'd2,  0},
      '{0, 4'd0,  1, 1, 4'd3,  0},
      '{0, 4'd0,  1, 1, 4'd4,  0},
      '{0, 4'd0,  1, 1, 4'd7,  0},
      '{0, 4'd0,  1, 0, 4'd0,  0},
      '{1, 4'd6,  1, 1, 4'd6,  0},
      '{0, 4'd0,  1, 0, 4'd0,  0}
    };
    #12;
    check("rst_bus", bus, 4'hF);
    check("rst_req", bus_req, 0);
    check("rst_stb_o", bus_stb_o, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_ovf", rx_overflow, 0);
    check("rst_tmo", timeout_err, 0);
    #11 rst_n = 1'b1;
    step;
    check("idle_tx_ready", tx_ready, 1);
    // T1: transmit 12 with immediate grant
    tx_valid = 1; tx_data = 4'd12; bus_gnt = 1;
    step;
    tx_valid = 0;
    check("t1_req", bus_req, 1);
    check("t1_req_bus_z", bus, 4'hF);
    check("t1_req_stb_o", bus_stb_o, 0);
    check("t1_req_tx_ready", tx_ready, 0);
    step;
    check("t1_drive_bus", bus, 4'hC);
    check("t1_drive_stb_o", bus_stb_o, 1);
    check("t1_drive_req", bus_req, 1);
    bus_gnt = 0;
    bus_stb_i = 1;
    step;
    bus_stb_i = 0;
    check("t1_turn_bus_z", bus, 4'hF);
    check("t1_turn_stb_o", bus_stb_o, 0);
    check("t1_turn_req", bus_req, 0);
    check("t1_turn_tx_ready", tx_ready, 0);
    check("t1_own_stb_ignored", rx_valid, 0);
    step;
    check("t1_tx_ready_back", tx_ready, 1);
    // T2/T3/T4 and empty push+pop
    foreach (vec[i]) begin
      rx_drive(vec[i].stb, vec[i].d, vec[i].rdy);
      step;
      check($sformatf("rx%0d_valid", i), rx_valid, vec[i].v);
      check($sformatf("rx%0d_data", i), rx_data, vec[i].q);
      check($sformatf("rx%0d_ovf", i), rx_overflow, vec[i].o);
    end
    rx_drive(0, 0, 0);
    // T5: no grant for 20 cycles after tx 9
    tx_valid = 1; tx_data = 4'd9;
    step;
    tx_valid = 0;
    pulses = 0; driven = 0;
    for (int c = 0; c < 20; c++) begin
      step;
      pulses += int'(timeout_err);
      driven += int'(bus !== 4'hF || bus_stb_o);
    end
    check("t5_bus_never_driven", driven, 0);
`ifdef BUS_TIMEOUT_EN
    check("t5_tmo_pulses", pulses, 1);
    check("t5_tx_ready", tx_ready, 1);
    check("t5_req_low", bus_req, 0);
`else
    check("t5_tmo_pulses", pulses, 0);
    check("t5_still_req", bus_req, 1);
    check("t5_tx_ready_low", tx_ready, 0);
`endif
    bus_gnt = 1;
    repeat (3) step;
    bus_gnt = 0;
    check("t5_idle", tx_ready, 1);
    // T6: async reset mid-DRIVE with two words buffered
    rx_drive(1, 4'd3, 0);
    step;
    rx_drive(1, 4'd4, 0);
    step;
    rx_drive(0, 0, 0);
    check("t6_two_words", rx_data, 4'd3);
    tx_valid = 1; tx_data = 4'd5; bus_gnt = 1;
    step;
    tx_valid = 0;
    step;
    check("t6_drive_bus", bus, 4'h5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_bus_z", bus, 4'hF);
    check("t6_rst_req", bus_req, 0);
    check("t6_rst_stb_o", bus_stb_o, 0);
    check("t6_rst_rx_valid", rx_valid, 0);
    #3 rst_n = 1'b1;
    step;
    check("t6_tx_ready", tx_ready, 1);
    tx_valid = 1; tx_data = 4'd6;
    step;
    tx_valid = 0;
    step;
    check("t6_new_bus", bus, 4'h6);
    check("t6_new_stb_o", bus_stb_o, 1);
    step;
    check("t6_new_turn_z", bus, 4'hF);
    step;
    check("t6_new_tx_ready", tx_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
